// File: rtl/ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// ram_arb_pkg
// Shared types and default widths for the RAM port arbiter.
//   RAM_ADDR_W / RAM_DATA_W : default width of the HPS on-chip RAM s2 port
//   TAG_ID_W                : width of a requester id inside a read tag
//                             (large enough for the maximum of 4 requesters)
//   arb_state_e             : arbiter state (IDLE = round-robin, OWNED = locked)
//   rd_tag_t                : {valid, id} carried alongside an in-flight read
// -----------------------------------------------------------------------------
package ram_arb_pkg;

   localparam int RAM_ADDR_W = 13;
   localparam int RAM_DATA_W = 8;
   localparam int MAX_REQ    = 4;
   localparam int TAG_ID_W   = 2;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } rd_tag_t;

endpackage

// File: rtl/ram_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// ram_arb_rr_pick
// Combinational round-robin picker. The winner is the first requesting index
// strictly after i_ptr, wrapping modulo NUM_REQ (also for non-power-of-2
// NUM_REQ). i_ptr itself is considered last.
// Ports:
//   i_req  [NUM_REQ] : request vector
//   i_ptr  [PTR_W]   : index of the most recent winner
//   o_gnt  [NUM_REQ] : one-hot winner, all zero when nothing is requested
//   o_idx  [PTR_W]   : index of the winner (0 when nothing is requested)
// -----------------------------------------------------------------------------
module ram_arb_rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [PTR_W-1:0]   o_idx
);

   // Walk the candidates from the farthest (k = NUM_REQ, i.e. the pointer
   // itself) to the nearest (k = 1); the last hit wins, so the nearest
   // requester after the pointer takes priority.
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if ((i == ((int'(i_ptr) + k) % NUM_REQ)) && i_req[i]) begin
               o_gnt = NUM_REQ'(1) << i;
               o_idx = PTR_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// ram_port_arbiter
// Shares the single HPS on-chip RAM port between NUM_REQ fabric requesters
// (e.g. the ambilight zone-colour writer and the LED-strip reader).
//
// Handshake: a requester raises req[i] and holds req_we/req_addr/req_wdata
// (and req_lock) stable until it sees gnt[i]; the access is accepted in the
// cycle where req[i] & gnt[i] is true. gnt is combinational, at most one bit
// is set and never without the matching req. One access is accepted per
// cycle, back to back. Reads return one rvalid[i] strobe READ_LATENCY+1
// cycles after acceptance with rdata (broadcast) valid in that cycle.
//
// Ports:
//   clk, reset           : RAM port clock, asynchronous active-high reset
//   req/req_lock/req_we  : per-requester request, lock-next, write-enable
//   req_addr/req_wdata   : packed per-requester address / write data
//   gnt                  : one-hot combinational grant
//   rvalid/rdata         : read return strobe per requester, shared data
//   ram_*                : registered command to the RAM, ram_readdata back
//
// Arbitration: IDLE is round-robin. A winner holding req_lock becomes the
// owner (OWNED) and keeps the port for each following access while it keeps
// requesting and locking. After MAX_BURST owner grants with another
// requester waiting, the owner is skipped for one cycle and the pointer is
// left on the owner, so the others win first in IDLE.
// -----------------------------------------------------------------------------
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int ADDR_W       = RAM_ADDR_W,
   parameter int DATA_W       = RAM_DATA_W,
   parameter int READ_LATENCY = 1,
   parameter int MAX_BURST    = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_lock,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic [ADDR_W-1:0]         ram_address,
   output logic                      ram_chipselect,
   output logic                      ram_clken,
   output logic                      ram_write,
   output logic [DATA_W-1:0]         ram_writedata,
   input  logic [DATA_W-1:0]         ram_readdata
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   arb_state_e          r_state;
   logic [PTR_W-1:0]    r_ptr;
   logic [PTR_W-1:0]    r_owner;
   logic [CNT_W-1:0]    r_burst;

   logic                r_cs;
   logic                r_wr;
   logic                r_clken;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   rd_tag_t             r_cmd_tag;
   rd_tag_t             r_tag [READ_LATENCY];

   // ---------------------------------------------------------------------
   // Combinational arbitration
   // ---------------------------------------------------------------------
   logic [NUM_REQ-1:0]  w_pick_gnt;
   logic [PTR_W-1:0]    w_pick_idx;
   logic [NUM_REQ-1:0]  w_owner_oh;
   logic [NUM_REQ-1:0]  w_gnt;
   logic [PTR_W-1:0]    w_win_idx;
   logic                w_others;
   logic                w_burst_full;
   logic                w_accept;
   logic                w_sel_we;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;

   ram_arb_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_pick (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_gnt   (w_pick_gnt),
      .o_idx   (w_pick_idx)
   );

   assign w_owner_oh = NUM_REQ'(1) << r_owner;

   always_comb begin
      w_others     = |(req & ~w_owner_oh);
      w_burst_full = (r_burst == BURST_MAX);
      w_gnt        = '0;
      w_win_idx    = w_pick_idx;
      case (r_state)
         IDLE: begin
            w_gnt = w_pick_gnt;
         end
         OWNED: begin
            w_win_idx = r_owner;
            // Owner keeps the port unless its burst is used up while
            // somebody else is waiting; then it is skipped this cycle.
            if (req[r_owner] && !(w_burst_full && w_others)) begin
               w_gnt = w_owner_oh;
            end
         end
         default: begin
            w_gnt = '0;
         end
      endcase
      w_accept = |(w_gnt & req);
   end

   // Output grant is forced low while reset is held.
   assign gnt = reset ? '0 : w_gnt;

   // Select the winner's command fields.
   always_comb begin
      w_sel_we    = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win_idx == PTR_W'(i)) begin
            w_sel_we    = req_we[i];
            w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Arbiter FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_ptr   <= PTR_W'(NUM_REQ - 1);
         r_owner <= '0;
         r_burst <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_ptr <= w_win_idx;
                  if (req_lock[w_win_idx]) begin
                     r_state <= OWNED;
                     r_owner <= w_win_idx;
                     r_burst <= CNT_W'(1);
                  end
               end
            end
            OWNED: begin
               // Pointer stays on the owner so that, on return to IDLE,
               // everyone else is ahead of it.
               r_ptr <= r_owner;
               if (w_accept) begin
                  if (!w_burst_full) begin
                     r_burst <= r_burst + CNT_W'(1);
                  end
                  if (!req_lock[r_owner]) begin
                     r_state <= IDLE;
                     r_burst <= '0;
                  end
               end else begin
                  // Owner dropped its request, or was skipped at the
                  // burst limit.
                  r_state <= IDLE;
                  r_burst <= '0;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Registered RAM command and read-tag pipeline
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cs      <= 1'b0;
         r_wr      <= 1'b0;
         r_clken   <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_cmd_tag <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_tag[i] <= '0;
         end
      end else begin
         r_clken <= 1'b1;
         r_cs    <= w_accept;
         r_wr    <= w_accept & w_sel_we;
         if (w_accept) begin
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
         end
         // r_cmd_tag lines up with the command on the RAM port; r_tag then
         // delays it by the RAM read latency so the last stage lines up
         // with valid ram_readdata.
         r_cmd_tag.valid <= w_accept & ~w_sel_we;
         r_cmd_tag.id    <= TAG_ID_W'(w_win_idx);
         r_tag[0]        <= r_cmd_tag;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   always_comb begin
      rvalid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rvalid[i] = r_tag[READ_LATENCY-1].valid &&
                     (r_tag[READ_LATENCY-1].id == TAG_ID_W'(i));
      end
   end

   assign rdata          = ram_readdata;
   assign ram_address    = r_addr;
   assign ram_writedata  = r_wdata;
   assign ram_chipselect = r_cs;
   assign ram_write      = r_wr;
   assign ram_clken      = r_clken;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_port_arbiter
// Bench for ram_port_arbiter with two requesters and a behavioural RAM.
// A negedge monitor holds a rule-level model of the arbiter (last winner,
// current owner, owner run length) and a model memory, and compares every
// DUT output each cycle. Directed vectors, hand sequences and randomized
// traffic drive the inputs.
// -----------------------------------------------------------------------------
module tb_ram_port_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 13;
  localparam int DW   = 8;
  localparam int RL   = 1;
  localparam int MAXB = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req, req_lock, req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt, rvalid;
  logic [DW-1:0]      rdata;
  logic [AW-1:0]      ram_address;
  logic               ram_chipselect, ram_clken, ram_write;
  logic [DW-1:0]      ram_writedata, ram_readdata;

  ram_port_arbiter #(
    .NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_lock(req_lock), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect),
    .ram_clken(ram_clken), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
  );

  // ---------------- behavioural RAM (1-cycle read) ----------------
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_chipselect && ram_clken) begin
      if (ram_write) ram_mem[ram_address] <= ram_writedata;
      else           ram_readdata <= ram_mem[ram_address];
    end
  end

  // ---------------- check bookkeeping ----------------
  int checks;
  int failures;
  int cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] mmem [0:(1<<AW)-1];
  logic [25:0]   exp_q[$];          // {due_cycle[15:0], id[1:0], data[7:0]}
  int            m_last;            // most recent winner (round-robin pointer)
  int            m_owner;           // locked owner, -1 when none
  int            m_run;             // owner grants in the current burst
  logic          p_cs, p_we, exp_clken;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wd;

  always @(negedge clk) begin
    int          win;
    logic [1:0]  e_gnt, e_rv;
    logic [7:0]  e_rd;
    logic [25:0] ent;
    if (reset) begin
      chk("rst_gnt",    32'(gnt), 32'd0);
      chk("rst_cs",     32'(ram_chipselect), 32'd0);
      chk("rst_write",  32'(ram_write), 32'd0);
      chk("rst_addr",   32'(ram_address), 32'd0);
      chk("rst_wdata",  32'(ram_writedata), 32'd0);
      chk("rst_clken",  32'(ram_clken), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      m_last = NREQ - 1; m_owner = -1; m_run = 0;
      exp_q.delete();
      p_cs = 1'b0; p_we = 1'b0; exp_clken = 1'b0;
    end else begin
      chk("clken", 32'(ram_clken), 32'(exp_clken));
      exp_clken = 1'b1;
      // command issued for last cycle's accept
      chk("cs",    32'(ram_chipselect), 32'(p_cs));
      chk("write", 32'(ram_write), 32'(p_cs & p_we));
      if (p_cs) begin
        chk("addr", 32'(ram_address), 32'(p_addr));
        if (p_we) begin
          chk("wdata", 32'(ram_writedata), 32'(p_wd));
          mmem[p_addr] = p_wd;
        end
      end
      // read returns due this cycle
      e_rv = 2'b00; e_rd = 8'h00;
      if (exp_q.size() > 0 && exp_q[0][25:10] == 16'(cyc)) begin
        ent  = exp_q.pop_front();
        e_rv = 2'b01 << ent[9:8];
        e_rd = ent[7:0];
      end
      chk("rvalid", 32'(rvalid), 32'(e_rv));
      if (e_rv != 2'b00) chk("rdata", 32'(rdata), 32'(e_rd));
      // who should win this cycle
      win = -1;
      if (m_owner >= 0) begin
        if (req[m_owner] &&
            !(m_run >= MAXB && (req & ~(2'b01 << m_owner)) != 2'b00))
          win = m_owner;
      end else begin
        for (int k = 1; k <= NREQ; k++)
          if (win < 0 && req[(m_last + k) % NREQ]) win = (m_last + k) % NREQ;
      end
      e_gnt = (win >= 0) ? (2'b01 << win) : 2'b00;
      chk("gnt", 32'(gnt), 32'(e_gnt));
      p_cs = (win >= 0);
      p_we = 1'b0;
      if (win >= 0) begin
        p_we   = req_we[win];
        p_addr = req_addr[win*AW +: AW];
        p_wd   = req_wdata[win*DW +: DW];
        if (!p_we) exp_q.push_back({16'(cyc + 1 + RL), 2'(win), mmem[p_addr]});
      end
      // advance model
      if (m_owner >= 0) begin
        if (win == m_owner) begin
          m_run = (m_run < MAXB) ? m_run + 1 : MAXB;
          if (!req_lock[m_owner]) m_owner = -1;
        end else begin
          m_owner = -1;
        end
      end else if (win >= 0) begin
        m_last = win;
        if (req_lock[win]) begin m_owner = win; m_run = 1; end
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w);
    req = r; req_lock = l; req_we = w;
  endtask

  task automatic set_addr(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0] req;
    logic [1:0] lock;
    logic [1:0] we;
    logic [1:0] exp_gnt;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  initial begin
    int acc1, g1_before, wait0, budget;
    bit got0, check_resume, burst;

    // req, lock, we, expected gnt (pointer starts at requester 1)
    tbl[0]  = '{2'b00, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{2'b01, 2'b00, 2'b01, 2'b01};  // write 0x10 = A5
    tbl[2]  = '{2'b01, 2'b00, 2'b00, 2'b01};  // read back 0x10
    tbl[3]  = '{2'b11, 2'b00, 2'b00, 2'b10};  // alternate 1,0,1,0
    tbl[4]  = '{2'b11, 2'b00, 2'b00, 2'b01};
    tbl[5]  = '{2'b11, 2'b00, 2'b00, 2'b10};
    tbl[6]  = '{2'b11, 2'b00, 2'b00, 2'b01};
    tbl[7]  = '{2'b10, 2'b00, 2'b10, 2'b10};  // write 0x20 = 3C
    tbl[8]  = '{2'b10, 2'b00, 2'b00, 2'b10};
    tbl[9]  = '{2'b01, 2'b00, 2'b00, 2'b01};
    tbl[10] = '{2'b11, 2'b10, 2'b00, 2'b10};  // 1 wins and locks
    tbl[11] = '{2'b11, 2'b10, 2'b00, 2'b10};  // owner kept
    tbl[12] = '{2'b11, 2'b00, 2'b00, 2'b10};  // owner releases after this
    tbl[13] = '{2'b11, 2'b00, 2'b00, 2'b01};
    tbl[14] = '{2'b01, 2'b01, 2'b00, 2'b01};  // 0 locks
    tbl[15] = '{2'b10, 2'b00, 2'b00, 2'b00};  // owner drops req: nobody
    tbl[16] = '{2'b10, 2'b00, 2'b00, 2'b10};  // 1 served next cycle
    tbl[17] = '{2'b11, 2'b01, 2'b00, 2'b01};  // 0 locks
    tbl[18] = '{2'b11, 2'b11, 2'b00, 2'b01};  // lock by non-owner ignored
    tbl[19] = '{2'b10, 2'b10, 2'b00, 2'b00};  // owner drops
    tbl[20] = '{2'b11, 2'b00, 2'b00, 2'b10};
    tbl[21] = '{2'b00, 2'b00, 2'b00, 2'b00};

    checks = 0; failures = 0; cyc = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] <= 8'(i * 7 + 3);
      mmem[i]     = 8'(i * 7 + 3);
    end
    ram_mem[1] <= 8'h11; mmem[1] = 8'h11;
    ram_mem[2] <= 8'h22; mmem[2] = 8'h22;

    reset = 1'b1;
    drive(2'b00, 2'b00, 2'b00);
    set_addr(13'h0010, 13'h0020, 8'hA5, 8'h3C);
    repeat (3) next_cycle;
    reset = 1'b0;

    // ---- table-driven vectors ----
    for (int i = 0; i < NV; i++) begin
      next_cycle;
      drive(tbl[i].req, tbl[i].lock, tbl[i].we);
      #3;
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].exp_gnt));
    end

    // ---- interleaved reads from both requesters ----
    set_addr(13'h0001, 13'h0002, 8'h00, 8'h00);
    next_cycle; drive(2'b01, 2'b00, 2'b00);
    next_cycle; drive(2'b10, 2'b00, 2'b00);
    next_cycle; drive(2'b00, 2'b00, 2'b00);
    #3;
    chk("ilv_rvalid0", 32'(rvalid), 32'h1);
    chk("ilv_rdata0",  32'(rdata),  32'h11);
    next_cycle; #3;
    chk("ilv_rvalid1", 32'(rvalid), 32'h2);
    chk("ilv_rdata1",  32'(rdata),  32'h22);
    next_cycle; #3;
    chk("ilv_rvalid_end", 32'(rvalid), 32'h0);

    // ---- locked burst against a waiting requester ----
    set_addr(13'h0030, 13'h0040, 8'h00, 8'h00);
    acc1 = 0; g1_before = 0; wait0 = 0; budget = 0;
    got0 = 1'b0; check_resume = 1'b0;
    next_cycle; drive(2'b10, 2'b10, 2'b00);
    #3;
    if (gnt[1]) acc1++;
    while (acc1 < 40 && budget < 200) begin
      next_cycle;
      drive({1'b1, ~got0}, 2'b10, 2'b00);
      #3;
      budget++;
      if (!got0) wait0++;
      if (check_resume) begin
        chk("burst_resume", 32'(gnt), 32'h2);
        check_resume = 1'b0;
      end
      if (gnt[0]) begin
        got0 = 1'b1; g1_before = acc1; check_resume = 1'b1;
      end
      if (gnt[1]) acc1++;
    end
    chk("burst_done",      32'(acc1), 32'd40);
    chk("burst_got0",      32'(got0), 32'd1);
    chk("burst_len",       32'(g1_before), 32'd16);
    chk("burst_wait_le17", 32'(wait0 <= 17), 32'd1);
    next_cycle; drive(2'b00, 2'b00, 2'b00);

    // ---- reset right after a read accept ----
    set_addr(13'h0010, 13'h0020, 8'h00, 8'h00);
    next_cycle; drive(2'b01, 2'b00, 2'b00);
    #3;
    chk("rr_read_gnt", 32'(gnt), 32'h1);
    next_cycle;
    reset = 1'b1;
    drive(2'b11, 2'b00, 2'b00);
    #1;
    chk("rr_cs",     32'(ram_chipselect), 32'd0);
    chk("rr_gnt",    32'(gnt), 32'd0);
    chk("rr_clken",  32'(ram_clken), 32'd0);
    chk("rr_rvalid", 32'(rvalid), 32'd0);
    next_cycle; #3;
    chk("rr_rvalid_late", 32'(rvalid), 32'd0);
    next_cycle;
    reset = 1'b0;
    drive(2'b11, 2'b00, 2'b00);
    #3;
    chk("rr_first_gnt", 32'(gnt), 32'h1);
    next_cycle; drive(2'b00, 2'b00, 2'b00);
    next_cycle;

    // ---- randomized traffic; even 100-cycle blocks plain, odd blocks
    //      hold requester 1 busy with both locks asserted ----
    for (int i = 0; i < 800; i++) begin
      next_cycle;
      burst = ((i / 100) % 2) == 1;
      reset = !burst && ($urandom_range(0, 149) == 0);
      if (burst) begin
        req      = {1'b1, 1'($urandom)};
        req_lock = 2'b11;
      end else begin
        req      = 2'($urandom);
        req_lock = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      end
      req_we = 2'($urandom);
      set_addr(13'($urandom_range(0, 15)), 13'($urandom_range(0, 15)),
               8'($urandom), 8'($urandom));
    end

    reset = 1'b0;
    drive(2'b00, 2'b00, 2'b00);
    repeat (5) next_cycle;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
